// File: rtl/vga_sync_if.sv
// Bundle of VGA timing outputs shared between the sync generator and its consumers.
// With VGA_FRAME_CNT_EN defined the bundle also carries the 8-bit frame counter.
interface vga_sync_if;
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    modport master (
        output p_tick, x, y, video_on, hsync, vsync, frame_start
`ifdef VGA_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        input p_tick, x, y, video_on, hsync, vsync, frame_start
`ifdef VGA_FRAME_CNT_EN
        , input frame_cnt
`endif
    );
endinterface

// File: rtl/vga_sync_gen.sv
// Free-running 640x480@60 VGA timing generator: pixel enable, x/y counters, syncs, frame strobe.
// Optional VGA_FRAME_CNT_EN adds an 8-bit frame counter to the output bundle.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    vga_sync_if.master vga
);
    localparam int H_TOTAL  = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_DISPLAY + H_FP;
    localparam int HS_END   = H_DISPLAY + H_FP + H_SYNC - 1;
    localparam int VS_START = V_DISPLAY + V_FP;
    localparam int VS_END   = V_DISPLAY + V_FP + V_SYNC - 1;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [9:0]       x_q;
    logic [9:0]       y_q;
    logic [9:0]       x_next;
    logic [9:0]       y_next;
    logic             frame_wrap;
    logic             p_tick_q;
    logic             hsync_q;
    logic             vsync_q;
    logic             video_on_q;
    logic             frame_start_q;

    assign tick = (div == DIV_W'(CLK_DIV - 1));

    always_comb begin
        x_next     = x_q;
        y_next     = y_q;
        frame_wrap = 1'b0;
        if (tick) begin
            if (x_q == 10'(H_TOTAL - 1)) begin
                x_next = '0;
                if (y_q == 10'(V_TOTAL - 1)) begin
                    y_next     = '0;
                    frame_wrap = 1'b1;
                end else begin
                    y_next = y_q + 10'd1;
                end
            end else begin
                x_next = x_q + 10'd1;
            end
        end
    end

    // Syncs and blanking decode the next counter values so they change in the same clk as x/y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div           <= '0;
            x_q           <= '0;
            y_q           <= '0;
            p_tick_q      <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b1;
        end else begin
            div           <= tick ? '0 : div + 1'b1;
            x_q           <= x_next;
            y_q           <= y_next;
            p_tick_q      <= tick;
            frame_start_q <= frame_wrap;
            hsync_q       <= !((x_next >= 10'(HS_START)) && (x_next <= 10'(HS_END)));
            vsync_q       <= !((y_next >= 10'(VS_START)) && (y_next <= 10'(VS_END)));
            video_on_q    <= (x_next < 10'(H_DISPLAY)) && (y_next < 10'(V_DISPLAY));
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (frame_wrap) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign vga.frame_cnt = frame_cnt_q;
`endif

    assign vga.p_tick      = p_tick_q;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.video_on    = video_on_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: full-size instance plus a shrunken-timing instance.
// Expected outputs come from a closed-form model indexed by clk edges since reset release.
module tb_vga_sync_gen;
    typedef struct {
        int         k;
        logic [9:0] x;
        logic [9:0] y;
        logic       pt;
        logic       vo;
        logic       hs;
        logic       vs;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    longint k = 0;
    int     checks = 0;
    int     errors = 0;

    vga_sync_if if_a ();
    vga_sync_if if_b ();

    vga_sync_gen dut_a (.clk(clk), .rst_n(rst_n), .vga(if_a));

    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_DISPLAY(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (.clk(clk), .rst_n(rst_n), .vga(if_b));

    always #5 clk = ~clk;

    // Layout: [32:25] frame_cnt, [24] frame_start, [23] p_tick, [22] video_on, [21] hsync, [20] vsync, [19:10] y, [9:0] x
    function automatic logic [63:0] modelAt(longint kk, int d, int hd, int hf, int hsw, int hb,
                                            int vd, int vf, int vsw, int vb);
        longint     ht, vt, p, col, row;
        logic       pt, fs, vo, hs, vs;
        logic [7:0] fc;
        ht  = hd + hf + hsw + hb;
        vt  = vd + vf + vsw + vb;
        p   = kk / d;
        col = p % ht;
        row = (p / ht) % vt;
        pt  = (kk > 0) && (kk % d == 0);
        fs  = pt && (p % (ht * vt) == 0);
        vo  = (col < hd) && (row < vd);
        hs  = !((col >= hd + hf) && (col < hd + hf + hsw));
        vs  = !((row >= vd + vf) && (row < vd + vf + vsw));
`ifdef VGA_FRAME_CNT_EN
        fc  = 8'((p / (ht * vt)) % 256);
`else
        fc  = 8'd0;
`endif
        return {31'b0, fc, fs, pt, vo, hs, vs, 10'(row), 10'(col)};
    endfunction

    function automatic logic [63:0] packA();
        logic [7:0] fc;
`ifdef VGA_FRAME_CNT_EN
        fc = if_a.frame_cnt;
`else
        fc = 8'd0;
`endif
        return {31'b0, fc, if_a.frame_start, if_a.p_tick, if_a.video_on, if_a.hsync, if_a.vsync, if_a.y, if_a.x};
    endfunction

    function automatic logic [63:0] packB();
        logic [7:0] fc;
`ifdef VGA_FRAME_CNT_EN
        fc = if_b.frame_cnt;
`else
        fc = 8'd0;
`endif
        return {31'b0, fc, if_b.frame_start, if_b.p_tick, if_b.video_on, if_b.hsync, if_b.vsync, if_b.y, if_b.x};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
        end
    endtask

    task automatic checkBoth();
        checkOutput("model_a", packA(), modelAt(k, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        checkOutput("model_b", packB(), modelAt(k, 2, 6, 2, 3, 2, 4, 1, 2, 1));
    endtask

    // One clk edge; outputs are sampled 1 ns after it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (rst_n) k++;
        checkBoth();
    endtask

    task automatic pulseReset(input int hold);
        rst_n = 1'b0;
        k = 0;
        #1;
        checkBoth();
        checkOutput("async_reset_b", packB() & 64'hFFFFFF, {40'b0, 1'b0, 1'b1, 1'b1, 1'b1, 20'b0});
        for (int i = 0; i < hold; i++) applyStimulus();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs[$];

    initial begin
        longint hs_edge;
        vecs.push_back('{1,    10'd0,   10'd0, 1'b0, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{3,    10'd0,   10'd0, 1'b0, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{4,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{5,    10'd1,   10'd0, 1'b0, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{8,    10'd2,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{2559, 10'd639, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{2560, 10'd640, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{2623, 10'd655, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{2624, 10'd656, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{3004, 10'd751, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{3008, 10'd752, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{3199, 10'd799, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{3200, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{5760, 10'd640, 10'd1, 1'b1, 1'b0, 1'b1, 1'b1});

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus();
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            while (k < vecs[i].k) applyStimulus();
            checkOutput($sformatf("vec_%0d", vecs[i].k), packA() & 64'hFFFFFF,
                        {40'b0, vecs[i].pt, vecs[i].vo, vecs[i].hs, vecs[i].vs, vecs[i].y, vecs[i].x});
        end

        // Mid-frame reset, then the first hsync of line 0 must start at x = 8 (edge 16).
        @(posedge clk);
        #1;
        pulseReset(3);
        hs_edge = -1;
        for (int i = 0; i < 200 && hs_edge < 0; i++) begin
            applyStimulus();
            if (if_b.hsync === 1'b0) hs_edge = k;
        end
        checkOutput("first_hsync_edge", 64'(hs_edge), 64'd16);
        checkOutput("first_hsync_y", {54'b0, if_b.y}, 64'd0);

        // Run past 257 shrunken frames (208 clks each) so the 8-bit frame counter wraps to 1.
        while (k < 257 * 208 + 10) applyStimulus();
`ifdef VGA_FRAME_CNT_EN
        checkOutput("frame_cnt_wrap", {56'b0, if_b.frame_cnt}, 64'd1);
`endif

        for (int r = 0; r < 8; r++) begin
            int run_len;
            run_len = int'($urandom_range(50, 2500));
            for (int i = 0; i < run_len; i++) applyStimulus();
            #(int'($urandom_range(0, 3)));
            pulseReset(int'($urandom_range(1, 4)));
        end
        for (int i = 0; i < 300; i++) applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates 640x480@60 Hz VGA timing from the 100 MHz system clock.
- Produces the pixel coordinates, the `video_on` blanking flag and active-low sync pulses.
- Feeds the text/menu overlay stage (its `x`, `y` and `video_on` inputs) and the VGA pins.
- Also supplies a pixel-rate enable and a frame-start strobe for game logic.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate); must be ≥2.
- H_DISPLAY, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_DISPLAY, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).

Ports:
- clk  input  1  system clock, 100 MHz; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- p_tick  output  1  pixel enable, high one clk every CLK_DIV clks.
- x  output  10  current pixel column, 0..H_TOTAL-1.
- y  output  10  current line, 0..V_TOTAL-1.
- video_on  output  1  high when x < H_DISPLAY and y < V_DISPLAY.
- hsync  output  1  horizontal sync, active low.
- vsync  output  1  vertical sync, active low.
- frame_start  output  1  one-clk strobe when counters wrap to (0,0).
- frame_cnt  output  8  frame counter; present only with VGA_FRAME_CNT_EN.

Behaviour:
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_DISPLAY+V_FP+V_SYNC+V_BP (525).
- Reset (async assert, sync release on clk): div=0, x=0, y=0, p_tick=0, frame_start=0, hsync=1, vsync=1, video_on=1, frame_cnt=0.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - p_tick is registered, high in the clk after div==CLK_DIV-1.
  - First p_tick occurs on the CLK_DIV-th rising edge after reset release.
- Counters advance only on clk edges where the internal tick condition (div==CLK_DIV-1) holds.
- Horizontal: x increments; at x==H_TOTAL-1 it wraps to 0 and y advances.
- Vertical: y increments on horizontal wrap; at y==V_TOTAL-1 it wraps to 0.
- Timing relationship: x and y change in the same clk in which p_tick rises. Downstream samples x/y/video_on on any clk and sees stable values for CLK_DIV clks.
- Sync and blanking outputs:
  - hsync, vsync and video_on are registered and decoded from the next counter values, so they are exactly aligned with x/y (zero skew).
  - hsync=0 iff H_DISPLAY+H_FP ≤ x ≤ H_DISPLAY+H_FP+H_SYNC-1 (656..751).
  - vsync=0 iff V_DISPLAY+V_FP ≤ y ≤ V_DISPLAY+V_FP+V_SYNC-1 (490..491).
  - video_on = (x<H_DISPLAY)&&(y<V_DISPLAY).
- frame_start:
  - High for exactly one clk, in the clk where x,y transition from (H_TOTAL-1,V_TOTAL-1) to (0,0).
  - Never asserted by reset itself.
- Widths: x and y are 10 bits; all comparisons are unsigned. No counter exceeds its TOTAL-1.
- Reset mid-frame: all state returns to reset values immediately (async). Timing restarts at (0,0) with a full first line; there are no partial sync pulses after release.
- No inputs other than clk and rst_n; the block is free-running.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - `frame_cnt[7:0]` port exists, resets to 0.
  - It increments by 1 in the same clk frame_start is high and wraps 255→0. Used for blink and animation timing.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release → p_tick first high on clk edge 4, x=1 at that edge; p_tick period exactly 4 clks thereafter.
- Run one line → hsync falls when x becomes 656 and rises when x becomes 752; video_on falls when x becomes 640 and rises when x wraps to 0; line length 3200 clks.
- Run one frame → vsync low exactly for y=490..491 (2×3200 = 6400 clks); y wraps 524→0; frame_start period 1,680,000 clks, width 1 clk.
- Assert rst_n=0 at x=700,y=300 for 3 clks → x=y=0, hsync=vsync=1, p_tick=0 immediately; after release, first hsync low at x=656 of line 0.
- Check video_on over a full frame → high count = 640×480 = 307,200 pixel ticks; x never exceeds 799, y never exceeds 524.
- With VGA_FRAME_CNT_EN, run 257 frames → frame_cnt reads 1 after wrap (255→0→1), increments coincide with frame_start.
